uart_tx_arb: RTL
================

# uart_tx_arb

Round-robin arbiter that shares the single UART transmit byte stream among `N_REQ` independent requesters. Each requester presents a framed byte stream (valid/ready plus a last flag). The arbiter locks the transmitter to one requester until that frame ends or a burst limit is hit, so frames are never interleaved on the serial line. It sits between the requesting blocks and the `i_data`/`i_valid`/`o_ready` transmit port of `uart`.

## Interface
- `N_REQ`, default 4 — number of requesters, 2..16.
- `MAX_BURST`, default 16 — maximum bytes per grant before forced release; 0 = unlimited (release only on last).
- `i_clk` in 1 — system clock.
- `i_rst` in 1 — synchronous, active-high reset.
- `i_req_data` in 8*N_REQ — packed request bytes; requester k occupies bits [8k+7:8k].
- `i_req_valid` in N_REQ — per-requester byte valid.
- `i_req_last` in N_REQ — per-requester last byte of frame; qualified by valid.
- `o_req_ready` in→out N_REQ — per-requester ready; at most one bit set.
- `o_data` out 8 — byte to UART transmitter.
- `o_valid` out 1 — byte valid to UART transmitter.
- `i_ready` in 1 — UART transmitter ready.
- `o_grant` out N_REQ — one-hot current owner; all-zero when idle.
- `o_busy` out 1 — high while a grant is held.

## Operation
- Two states: IDLE, LOCKED.
- IDLE: if any `i_req_valid` bit is set, select the first set bit at or after the rotating pointer `ptr` (wrapping modulo N_REQ), register it into `o_grant`, clear the burst counter, and go to LOCKED. If none is set, stay in IDLE.
- LOCKED: pure combinational pass-through from granted requester g:
  - `o_data` = byte g.
  - `o_valid` = `i_req_valid[g]`.
  - `o_req_ready[g]` = `i_ready`; all other ready bits are 0.
- Transfer: a transfer is `o_valid && i_ready`. Each transfer increments the burst counter.
- Release: on a transfer where `i_req_last[g]`=1, or where the counter reaches MAX_BURST (when MAX_BURST≠0):
  - go to IDLE;
  - set `ptr` = (g+1) mod N_REQ;
  - clear `o_grant`.
- The counter is `$clog2(MAX_BURST+1)` bits wide and never wraps, because release happens at MAX_BURST.
- Granted requester drops valid mid-frame: grant is held indefinitely and `o_valid`=0; no timeout.
- In IDLE, `o_data`=0, `o_valid`=0 and `o_req_ready`=0.
- Non-granted requesters' valid/last/data are ignored. They must hold their byte stable (AXI-style: no retraction once valid).

## Timing
- Reset values:
  - state IDLE, `ptr`=0, counter 0;
  - `o_grant`=0, `o_busy`=0;
  - `o_valid`=0, `o_data`=0, `o_req_ready`=0.
- Arbitration latency: one cycle. A request seen in IDLE at cycle t gives grant visible at t+1, and the first transfer is possible at t+1.
- Release bubble: after a releasing transfer at cycle t, the state is IDLE at t+1. The next grant is visible at t+2 at the earliest, so there is one idle cycle between grants.
- Data/valid/ready paths in LOCKED are combinational; there is no added latency per byte.
- Simultaneous requests are resolved by `ptr` only. A releasing requester has lowest priority at the next arbitration.
- Reset mid-frame: the grant drops on the cycle after `i_rst` is sampled. The remaining bytes of the frame are not sent until re-arbitrated. The transmitter may already hold an accepted byte; that byte completes independently.

## Structure
- `uart_pkg` holds:
  - the state enum (IDLE, LOCKED);
  - the `UART_BYTE_W`=8 constant;
  - a function for the burst counter width.
- One sub-module, `uart_rr_pick`: combinational rotating-priority picker. Inputs are the request vector and `ptr`; outputs are a one-hot select and its index. It is reusable by the future RX demux.
- Top `uart_tx_arb`: FSM, `ptr`, burst counter and output mux. Estimated at 150–250 lines total.

## Test plan
- Single requester: req1 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3) with `i_ready`=1.
  - `o_grant`=0b0010 one cycle after valid.
  - Output is 0xA1, 0xA2, 0xA3 on consecutive cycles, then `o_grant`=0.
- Contention: req0–3 all valid with 1-byte frames, `ptr`=0. Grants follow order 0, 1, 2, 3, 0, with one idle cycle between each.
- Burst limit: MAX_BURST=4; req2 sends 6 bytes, and req0 is waiting.
  - After 4 transfers, req2 is released and req0 is granted.
  - req2 is re-granted later to finish its last 2 bytes.
- Backpressure: `i_ready` low for 5 cycles mid-frame.
  - `o_data` stays stable and `o_req_ready[g]`=0.
  - No byte is lost or duplicated.
  - Grant is held throughout.
- Reset mid-frame: assert `i_rst` after byte 2 of 5.
  - Next cycle: `o_grant`=0, `o_valid`=0, `ptr`=0.
  - Re-arbitration starts from req0.
- Valid gap: granted requester drops valid for 3 cycles while req3 is waiting. The grant is not transferred and `o_valid`=0 during the gap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and related blocks.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // An unlimited burst (0) still gets a one-bit counter so the register never collapses.
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return (max_burst == 0) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping modulo N.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         sel_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(N);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    sel_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        sel_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter locking the UART transmit byte stream to one requester
// until its frame ends or the burst limit forces a release.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [UART_BYTE_W*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [N_REQ-1:0]             i_req_last,
  output logic [N_REQ-1:0]             o_req_ready,
  output logic [UART_BYTE_W-1:0]       o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [N_REQ-1:0]             o_grant,
  output logic                         o_busy
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = burst_cnt_w(MAX_BURST);

  arb_state_e     state_q;
  logic [PW-1:0]  ptr_q;
  logic [PW-1:0]  ptr_d;
  logic [PW-1:0]  gidx_q;
  logic [N_REQ-1:0] grant_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  logic [N_REQ-1:0] pick_sel;
  logic [PW-1:0]    pick_idx;
  logic             xfer;
  logic             burst_hit;
  logic             release_now;

  uart_rr_pick #(.N(N_REQ)) u_pick (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .sel_o (pick_sel),
    .idx_o (pick_idx)
  );

  always_comb begin
    o_data      = '0;
    o_valid     = 1'b0;
    o_req_ready = '0;
    if (state_q == LOCKED) begin
      o_valid             = i_req_valid[gidx_q];
      o_req_ready[gidx_q] = i_ready;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (gidx_q == PW'(k)) begin
          o_data = i_req_data[k*UART_BYTE_W +: UART_BYTE_W];
        end
      end
    end
  end

  assign xfer        = o_valid & i_ready;
  // Count is pre-increment here, so MAX_BURST-1 marks the MAX_BURST-th transfer.
  assign burst_hit   = (MAX_BURST != 0) && (cnt_q == CW'(MAX_BURST - 1));
  assign release_now = xfer & (i_req_last[gidx_q] | burst_hit);
  assign ptr_d       = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + PW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|i_req_valid) begin
            state_q <= LOCKED;
            grant_q <= pick_sel;
            gidx_q  <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOCKED: begin
          if (release_now) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
            grant_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;

endmodule
